// File: rtl/barrel_pkg.sv
// Shared op encodings and the mux-level to pipeline-stage split helpers for the barrel shifter.
package barrel_pkg;

    localparam int unsigned OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_SLL = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_SRL = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_SRA = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_ROL = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_ROR = 3'd4;

    function automatic int unsigned lvls_per_stage(input int unsigned sa_w, input int unsigned stages);
        return (sa_w + stages - 1) / stages;
    endfunction

    function automatic int unsigned stage_lvl_lo(input int unsigned stage, input int unsigned sa_w,
                                                 input int unsigned stages);
        int unsigned lo;
        lo = stage * lvls_per_stage(sa_w, stages);
        return (lo > sa_w) ? sa_w : lo;
    endfunction

    // Trailing stages may end up with zero levels when the split does not divide evenly.
    function automatic int unsigned stage_lvl_cnt(input int unsigned stage, input int unsigned sa_w,
                                                  input int unsigned stages);
        int unsigned lo;
        int unsigned hi;
        lo = stage_lvl_lo(stage, sa_w, stages);
        hi = lo + lvls_per_stage(sa_w, stages);
        if (hi > sa_w) hi = sa_w;
        return hi - lo;
    endfunction

    function automatic logic op_is_rot(input logic [OP_WIDTH-1:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    function automatic logic op_is_left(input logic [OP_WIDTH-1:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic op_is_legal(input logic [OP_WIDTH-1:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operand/result streaming bus of the barrel shifter; slave is the shifter's view.
interface barrel_shifter_pipe_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned SA_WIDTH   = $clog2(DATA_WIDTH)
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [SA_WIDTH-1:0]   i_sa;
    logic [2:0]            i_op;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_zero;
    logic                  o_err;

    modport slave (
        input  i_valid, i_data, i_sa, i_op, i_ready,
        output o_ready, o_valid, o_data, o_zero, o_err
    );

    modport master (
        output i_valid, i_data, i_sa, i_op, i_ready,
        input  o_ready, o_valid, o_data, o_zero, o_err
    );
endinterface

// File: rtl/barrel_stage.sv
// One pipeline stage: applies its right-shift/rotate mux levels, then an enable-gated register.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned SA_WIDTH   = $clog2(DATA_WIDTH),
    parameter int unsigned LVL_LO     = 0,
    parameter int unsigned LVL_CNT    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [SA_WIDTH-1:0]   i_sa,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic                  i_fill,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [SA_WIDTH-1:0]   o_sa,
    output logic [OP_WIDTH-1:0]   o_op,
    output logic                  o_fill
);

    logic                    valid_d, valid_q;
    logic [DATA_WIDTH-1:0]   data_d, data_q;
    logic [SA_WIDTH-1:0]     sa_d, sa_q;
    logic [OP_WIDTH-1:0]     op_d, op_q;
    logic                    fill_d, fill_q;
    logic [2*DATA_WIDTH-1:0] wide;

    // Level k moves by 2^k; the upper half supplies either the fill bits or the wrapped bits.
    always_comb begin
        valid_d = i_valid;
        data_d  = i_data;
        sa_d    = i_sa;
        op_d    = i_op;
        fill_d  = i_fill;
        wide    = '0;
        for (int unsigned k = LVL_LO; k < LVL_LO + LVL_CNT; k++) begin
            wide = op_is_rot(i_op) ? {data_d, data_d} : {{DATA_WIDTH{i_fill}}, data_d};
            if (i_sa[k]) data_d = DATA_WIDTH'(wide >> (1 << k));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sa_q    <= '0;
            op_q    <= '0;
            fill_q  <= 1'b0;
        end else if (i_en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sa_q    <= sa_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sa    = sa_q;
    assign o_op    = op_q;
    assign o_fill  = fill_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with a global-stall valid/ready stream.
// Left ops are bit-reversed around a right-shift core; rotates are reduced mod DATA_WIDTH up front.
module barrel_shifter_pipe
    import barrel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned SA_WIDTH    = $clog2(DATA_WIDTH),
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    barrel_shifter_pipe_if.slave  bus
);

    localparam int unsigned NS = PIPE_STAGES;

    logic                  advance;
    logic [DATA_WIDTH-1:0] in_rev;
    logic [DATA_WIDTH-1:0] out_rev;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  pre_valid;
    logic [DATA_WIDTH-1:0] pre_data;
    logic [SA_WIDTH-1:0]   pre_sa;
    logic                  pre_fill;

    logic                  st_valid [NS+1];
    logic [DATA_WIDTH-1:0] st_data  [NS+1];
    logic [SA_WIDTH-1:0]   st_sa    [NS+1];
    logic [OP_WIDTH-1:0]   st_op    [NS+1];
    logic                  st_fill  [NS+1];
    logic                  tail_unused;

    // Illegal ops pass through unshifted; rotates wrap because sa < 2*DATA_WIDTH.
    always_comb begin
        in_rev = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) in_rev[i] = bus.i_data[DATA_WIDTH-1-i];
        pre_valid = bus.i_valid;
        pre_data  = op_is_left(bus.i_op) ? in_rev : bus.i_data;
        pre_fill  = (bus.i_op == OP_SRA) & bus.i_data[DATA_WIDTH-1];
        pre_sa    = bus.i_sa;
        if (!op_is_legal(bus.i_op)) begin
            pre_sa = '0;
        end else if (op_is_rot(bus.i_op) &&
                     ({1'b0, bus.i_sa} >= (SA_WIDTH+1)'(DATA_WIDTH))) begin
            pre_sa = SA_WIDTH'(bus.i_sa - SA_WIDTH'(DATA_WIDTH));
        end
    end

    assign st_valid[0] = pre_valid;
    assign st_data[0]  = pre_data;
    assign st_sa[0]    = pre_sa;
    assign st_op[0]    = bus.i_op;
    assign st_fill[0]  = pre_fill;

    assign advance     = !st_valid[NS] || bus.i_ready;
    assign bus.o_ready = advance;

    for (genvar s = 0; s < NS; s++) begin : g_stage
        barrel_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SA_WIDTH   (SA_WIDTH),
            .LVL_LO     (stage_lvl_lo(s, SA_WIDTH, NS)),
            .LVL_CNT    (stage_lvl_cnt(s, SA_WIDTH, NS))
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_en    (advance),
            .i_valid (st_valid[s]),
            .i_data  (st_data[s]),
            .i_sa    (st_sa[s]),
            .i_op    (st_op[s]),
            .i_fill  (st_fill[s]),
            .o_valid (st_valid[s+1]),
            .o_data  (st_data[s+1]),
            .o_sa    (st_sa[s+1]),
            .o_op    (st_op[s+1]),
            .o_fill  (st_fill[s+1])
        );
    end

    // Undo the input reversal for left ops and derive the result flags.
    always_comb begin
        out_rev = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) out_rev[i] = st_data[NS][DATA_WIDTH-1-i];
        res_data = op_is_left(st_op[NS]) ? out_rev : st_data[NS];
    end

    assign bus.o_valid = st_valid[NS];
    assign bus.o_data  = res_data;
    assign bus.o_zero  = st_valid[NS] && (res_data == '0);
    assign bus.o_err   = !op_is_legal(st_op[NS]);

    assign tail_unused = ^{st_sa[NS], st_fill[NS]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (DATA_WIDTH=10, PIPE_STAGES=2) with an arithmetic reference model.
module tb_barrel_shifter_pipe;
    import barrel_pkg::*;

    localparam int unsigned W  = 10;
    localparam int unsigned SA = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    logic [W:0] exp_q[$];
    int         pop_cyc[$];

    barrel_shifter_pipe_if #(.DATA_WIDTH(W), .SA_WIDTH(SA)) bus ();

    barrel_shifter_pipe #(.DATA_WIDTH(W), .SA_WIDTH(SA), .PIPE_STAGES(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {err, result} from plain integer arithmetic on the operand.
    function automatic logic [W:0] model(input logic [W-1:0] d, input logic [SA-1:0] sa,
                                         input logic [2:0] op);
        int unsigned x, s, m, r, e;
        logic err;
        x = d; s = sa; m = (1 << W) - 1; e = s % W; err = 1'b0;
        case (op)
            3'd0: r = (s >= W) ? 0 : ((x << s) & m);
            3'd1: r = (s >= W) ? 0 : (x >> s);
            3'd2: begin
                if (s >= W) r = d[W-1] ? m : 0;
                else begin
                    r = x >> s;
                    if (d[W-1]) r = r | (m & ~(m >> s));
                end
            end
            3'd3: r = ((x << e) | (x >> (W - e))) & m;
            3'd4: r = ((x >> e) | (x << (W - e))) & m;
            default: begin r = x; err = 1'b1; end
        endcase
        return {err, W'(r)};
    endfunction

    // Compare process: every output cycle against the model queue, plus the ready rule.
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst) begin
            chk("ready_rule", 32'(bus.o_ready), 32'(!bus.o_valid || bus.i_ready));
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.o_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("out_data", 32'(bus.o_data), 32'(e[W-1:0]));
                    chk("out_zero", 32'(bus.o_zero), 32'(e[W-1:0] == '0));
                    chk("out_err",  32'(bus.o_err),  32'(e[W]));
                    if (bus.i_ready) begin
                        void'(exp_q.pop_front());
                        pop_cyc.push_back(cyc);
                    end
                end
            end
            if (bus.i_valid && bus.o_ready) exp_q.push_back(model(bus.i_data, bus.i_sa, bus.i_op));
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [SA-1:0] sa, input logic [2:0] op);
        int n;
        bus.i_valid = 1'b1; bus.i_data = d; bus.i_sa = sa; bus.i_op = op;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.o_ready) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    // Single operand into an empty pipe with hand-computed expectations.
    task automatic run_one(input string nm, input logic [W-1:0] d, input logic [SA-1:0] sa,
                           input logic [2:0] op, input logic [W-1:0] exp_d, input logic exp_z,
                           input logic exp_e);
        int n;
        send(d, sa, op);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_valid && n < 20);
        chk({nm, "_latency"}, 32'(n), 32'd2);
        chk({nm, "_data"}, 32'(bus.o_data), 32'(exp_d));
        chk({nm, "_zero"}, 32'(bus.o_zero), 32'(exp_z));
        chk({nm, "_err"},  32'(bus.o_err),  32'(exp_e));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int sweep_done;
        logic [W-1:0] held;
        logic [W-1:0] dv [2];
        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        bus.i_data = '0; bus.i_sa = '0; bus.i_op = '0;

        chk("pin_sra",  32'(model(10'h200, 4'd3,  OP_SRA)), 32'h3C0);
        chk("pin_ror",  32'(model(10'h001, 4'd1,  OP_ROR)), 32'h200);
        chk("pin_rol",  32'(model(10'h003, 4'd11, OP_ROL)), 32'h006);
        chk("pin_ill",  32'(model(10'h155, 4'd3,  3'd6)),   32'h555);

        #3;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_data",  32'(bus.o_data),  32'd0);
        chk("rst_zero",  32'(bus.o_zero),  32'd0);
        chk("rst_err",   32'(bus.o_err),   32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;

        run_one("sra_neg",   10'h200, 4'd3,  OP_SRA, 10'h3C0, 1'b0, 1'b0);
        run_one("srl_big",   10'h3FF, 4'd12, OP_SRL, 10'h000, 1'b1, 1'b0);
        run_one("sra_big",   10'h3FF, 4'd12, OP_SRA, 10'h3FF, 1'b0, 1'b0);
        run_one("rol_mod",   10'h003, 4'd11, OP_ROL, 10'h006, 1'b0, 1'b0);
        run_one("ror_one",   10'h001, 4'd1,  OP_ROR, 10'h200, 1'b0, 1'b0);
        run_one("illegal",   10'h155, 4'd3,  3'd6,   10'h155, 1'b0, 1'b1);
        run_one("after_ill", 10'h155, 4'd1,  OP_SRL, 10'h0AA, 1'b0, 1'b0);

        // Back-to-back SLL of 1: results must leave on consecutive cycles.
        pop_cyc.delete();
        for (int i = 0; i < 10; i++) send(10'h001, SA'(i), OP_SLL);
        drain();
        chk("b2b_count", 32'(pop_cyc.size()), 32'd10);
        if (pop_cyc.size() == 10)
            for (int i = 1; i < 10; i++) chk("b2b_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

        // Three-cycle consumer stall with a full pipe.
        fork
            for (int i = 0; i < 6; i++) send(10'h005, SA'(i), OP_SLL);
            begin
                repeat (3) @(posedge clk);
                #1 bus.i_ready = 1'b0;
                held = bus.o_data;
                chk("stall_valid", 32'(bus.o_valid), 32'd1);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", 32'(bus.o_ready), 32'd0);
                    chk("stall_hold",  32'(bus.o_data),  32'(held));
                end
                @(posedge clk); #1 bus.i_ready = 1'b1;
            end
        join
        drain();

        // Every op and shift amount under a randomly stalling consumer.
        dv[0] = 10'h2D3; dv[1] = 10'h081;
        sweep_done = 0;
        fork
            begin
                for (int di = 0; di < 2; di++)
                    for (int op = 0; op < 8; op++)
                        for (int s = 0; s < 16; s++) send(dv[di], SA'(s), 3'(op));
                sweep_done = 1;
            end
            while (sweep_done == 0) begin
                @(posedge clk);
                #1 bus.i_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus.i_ready = 1'b1;
        drain();

        // Asynchronous reset with two operands in flight.
        send(10'h001, 4'd1, OP_SLL);
        send(10'h002, 4'd2, OP_SLL);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.o_valid), 32'd0);
        chk("midrst_data",  32'(bus.o_data),  32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("midrst_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        run_one("post_rst", 10'h3FF, 4'd2, OP_SRL, 10'h0FF, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Pipelined, parametrised barrel shifter/rotator with valid/ready streaming handshake.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right on DATA_WIDTH-bit operands.
- Shift network is log2-decomposed into SA_WIDTH mux stages, with a configurable number of register stages.
- Sits between an operand source (ALU issue / DSP datapath) and a consumer that may apply backpressure.

Parameters:
DATA_WIDTH, 10, operand/result width in bits (>=2, need not be a power of two)
SA_WIDTH, $clog2(DATA_WIDTH), shift-amount width
PIPE_STAGES, 2, number of register stages (1..SA_WIDTH); latency in cycles

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_valid  input  1  input operand valid
o_ready  output  1  block can accept an operand this cycle
i_data  input  DATA_WIDTH  operand
i_sa  input  SA_WIDTH  shift amount
i_op  input  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5..7 illegal
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_data  output  DATA_WIDTH  result
o_zero  output  1  result == 0
o_err  output  1  result came from an illegal op

Behaviour:
- Clocking and reset: one clock, i_clk. i_rst is asynchronous, active-high.
- Reset values: all stage valid bits 0, o_valid=0, o_data=0, o_zero=0, o_err=0. o_ready=1 once i_rst is deasserted.
- Reset mid-operation: all in-flight operands are discarded and never appear on the output.
- Handshake:
  - Global-stall pipeline: advance = !o_valid | i_ready; o_ready = advance.
  - Transfer in when i_valid & o_ready; transfer out when o_valid & i_ready.
  - When advance=0, every stage register holds its value, and o_data/o_zero/o_err stay stable while o_valid=1.
  - A bubble (i_valid=0 while advancing) propagates as valid=0.
- Latency: an accepted operand appears on o_valid exactly PIPE_STAGES cycles later when there is no stall. Sustained throughput is 1 operand per cycle.
- Stage mapping:
  - The SA_WIDTH mux levels (bit k shifts by 2^k) are split across the PIPE_STAGES register stages.
  - Each stage takes ceil(SA_WIDTH/PIPE_STAGES) levels; the last stage takes the remainder.
  - Each stage register carries data, the remaining sa bits, op, fill bit and valid.
- Arithmetic/width rules:
  - SLL: zero fill. If sa >= DATA_WIDTH the result is 0.
  - SRL: zero fill. If sa >= DATA_WIDTH the result is 0.
  - SRA: fill with i_data[DATA_WIDTH-1]. If sa >= DATA_WIDTH the result is all sign bits.
  - ROL/ROR: the effective amount is sa mod DATA_WIDTH. Because sa < 2*DATA_WIDTH, this is computed as sa - DATA_WIDTH when sa >= DATA_WIDTH, else sa, before stage 0.
  - Left operations use internal bit-reversal around the right-shift core, or a dedicated left core; both are acceptable if cycle behaviour is identical.
- Illegal op (5..7): o_data = i_data unchanged, o_err=1 with that result; the pipeline does not stop.
- o_zero is computed combinationally from o_data and is valid only when o_valid=1.
- Simultaneous in/out transfer in the same cycle when full is legal and loses no data.

Decomposition:
- Package barrel_pkg:
  - op encodings OP_SLL=0, OP_SRL=1, OP_SRA=2, OP_ROL=3, OP_ROR=4;
  - a function computing the levels-per-stage split.
- One sub-module, barrel_stage: parametrised by DATA_WIDTH and the level index range.
  - It applies its mux levels combinationally.
  - It has an enable-gated pipeline register with asynchronous-reset valid.
  - barrel_shifter_pipe instantiates PIPE_STAGES of them via generate, plus the input rotate-modulo/pre-reverse logic and output flag logic.

Test Plan:
(All with DATA_WIDTH=10, PIPE_STAGES=2.)
- SRA 10'b10_0000_0000 by sa=3, i_ready=1 -> o_valid 2 cycles later, o_data=10'b11_1100_0000, o_zero=0.
- SRL 10'h3FF by sa=12 (>=W) -> o_data=0, o_zero=1. Same operand with SRA -> 10'h3FF.
- ROL 10'b00_0000_0011 by sa=11 (mod -> 1) -> 10'b00_0000_0110. ROR 10'b00_0000_0001 by 1 -> 10'b10_0000_0000.
- Back-to-back SLL of 1 by sa=0..9, i_ready=1 -> results 1,2,4..512 on consecutive cycles with no bubbles. Then i_ready=0 for 3 cycles -> o_ready=0 and o_data held; resume -> order preserved and nothing lost.
- i_op=6, i_data=10'h155 -> o_data=10'h155, o_err=1. The next legal op has o_err=0.
- Assert i_rst asynchronously with 2 operands in flight -> o_valid=0 and o_data=0 immediately (before the next edge). After release, o_ready=1 and the first new operand emerges after 2 cycles.
